// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_CNT,
    S_DATA,
    S_CSUM,
    S_FILL,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [7:0] HDR_BYTE   = 8'hA5;
  localparam logic [7:0] HALT_INSTR = 8'hC0;
  localparam logic [2:0] OP_HALT    = 3'b110;

endpackage

// File: rtl/prog_loader_mem.sv
// Instruction store: register array that resets to HALT, one sync write port, one comb read port.
module loader_mem
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(HALT_INSTR);
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the CPU instruction store; holds the CPU until a good frame lands.
// Optional trailing XOR checksum enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_instr,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          err
);

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic          hold_q, done_q, err_q;
  logic          accept;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  assign in_ready = (state_q != S_FILL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = ptr_q[AW-1:0];
    wdata   = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_HDR: if (accept && in_data == DW'(HDR_BYTE)) state_d = S_CNT;
      S_CNT: if (accept) begin
        if (in_data != '0 && in_data <= DW'(DEPTH)) begin
          cnt_d   = in_data[AW:0];
          ptr_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_DATA;
        end else begin
          state_d = S_ERR;
        end
      end
      S_DATA: if (accept) begin
        we    = 1'b1;
        ptr_d = ptr_q + ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ in_data;
        if (ptr_q == cnt_q - ONE) state_d = S_CSUM;
`else
        if (ptr_q == cnt_q - ONE) state_d = (cnt_q == FULL) ? S_RUN : S_FILL;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) begin
        if (in_data != csum_q) state_d = S_ERR;
        else                   state_d = (cnt_q == FULL) ? S_RUN : S_FILL;
      end
`endif
      // Pointer already sits at N when FILL starts, so one HALT per cycle up to the last slot.
      S_FILL: begin
        we    = 1'b1;
        wdata = DW'(HALT_INSTR);
        ptr_d = ptr_q + ONE;
        if (ptr_q == FULL - ONE) state_d = S_RUN;
      end
      S_RUN, S_ERR: if (accept && in_data == DW'(HDR_BYTE)) state_d = S_CNT;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HDR;
      cnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= (state_d != S_RUN);
      done_q  <= (state_d == S_RUN);
      err_q   <= (state_d == S_ERR);
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign err       = err_q;

  loader_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_instr)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader; adds checksum bytes when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_instr;
  logic       cpu_hold, load_done, err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       hold;
    logic       done;
    logic       errv;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } memExp_t;

  memExp_t sb[$];
  vec_t    errVecs[5];

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_addr   (rd_addr),
    .rd_instr  (rd_instr),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkStatus(input string name, input logic hold, input logic done, input logic errv);
    checkOutput({name, " cpu_hold"}, {7'd0, cpu_hold}, {7'd0, hold});
    checkOutput({name, " load_done"}, {7'd0, load_done}, {7'd0, done});
    checkOutput({name, " err"}, {7'd0, err}, {7'd0, errv});
  endtask

  // Drive one byte and hold it until the loader accepts it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expectMem(input logic [3:0] a, input logic [7:0] d);
    memExp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drainMem(input string name);
    memExp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      #1;
      checkOutput($sformatf("%s slot%0d", name, e.addr), rd_instr, e.data);
    end
  endtask

  task automatic waitFill(input string name, input int expected);
    int c = 0;
    while (!in_ready && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput({name, " fill cycles"}, 8'(c), 8'(expected));
  endtask

  initial begin
    errVecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    errVecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1};
    errVecs[2] = '{8'h42, 1'b1, 1'b0, 1'b1};
    errVecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    errVecs[4] = '{8'h11, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkStatus("reset", 1'b1, 1'b0, 1'b0);
    checkOutput("reset in_ready", {7'd0, in_ready}, 8'h01);
    for (int k = 0; k < 16; k++) expectMem(4'(k), 8'hC0);
    drainMem("reset");

    // Bad counts 0 and 17 land in ERR; stray bytes in ERR are ignored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(errVecs[i].data);
      checkStatus($sformatf("errvec%0d", i), errVecs[i].hold, errVecs[i].done, errVecs[i].errv);
    end

    applyStimulus(8'hA5);
    checkStatus("frame3 hdr", 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h03);
    applyStimulus(8'h21);
    rd_addr = 4'h0;
    #1;
    checkOutput("write visible next cycle", rd_instr, 8'h21);
    applyStimulus(8'h4B);
    applyStimulus(8'hC0);
`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(8'hAA);
`endif
    checkOutput("fill in_ready", {7'd0, in_ready}, 8'h00);
    checkStatus("fill", 1'b1, 1'b0, 1'b0);
    waitFill("frame3", 13);
    checkStatus("frame3 run", 1'b0, 1'b1, 1'b0);
    expectMem(4'd0, 8'h21);
    expectMem(4'd1, 8'h4B);
    expectMem(4'd2, 8'hC0);
    for (int k = 3; k < 16; k++) expectMem(4'(k), 8'hC0);
    drainMem("frame3");

    applyStimulus(8'h77);
    checkStatus("run ignores byte", 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hA5);
    checkStatus("run restart", 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h10);
    for (int k = 0; k < 16; k++) applyStimulus(8'(k));
`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(8'h00);
`endif
    checkOutput("full in_ready", {7'd0, in_ready}, 8'h01);
    checkStatus("full run", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) expectMem(4'(k), 8'(k));
    drainMem("full");

`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h00);
    checkStatus("bad csum", 1'b1, 1'b0, 1'b1);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h26);
    waitFill("good csum", 14);
    checkStatus("good csum run", 1'b0, 1'b1, 1'b0);
    expectMem(4'd0, 8'h12);
    expectMem(4'd1, 8'h34);
    expectMem(4'd2, 8'hC0);
    drainMem("csum");
`endif

    applyStimulus(8'hA5);
    applyStimulus(8'h05);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    #2;
    reset = 1'b0;
    #1;
    checkStatus("mid reset", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) expectMem(4'(k), 8'hC0);
    drainMem("mid reset");
    @(negedge clk);
    reset = 1'b1;

    // A leading non-header byte must be ignored, proving the loader restarted in HDR.
    applyStimulus(8'h05);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h77);
`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(8'h77);
`endif
    waitFill("post reset", 15);
    checkStatus("post reset run", 1'b0, 1'b1, 1'b0);
    expectMem(4'd0, 8'h77);
    expectMem(4'd1, 8'hC0);
    drainMem("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
